psychic5_video_timing: RTL and testbench



---
 rtl/psychic5_video_pkg.sv | 58 +++++
 rtl/psychic5_video_timing_if.sv | 26 ++
 rtl/psychic5_wrap_counter.sv | 40 ++++
 rtl/psychic5_video_timing.sv | 149 ++++++++++++++
 tb/tb_psychic5_video_timing.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/psychic5_video_pkg.sv
// Shared raster constants and helpers for the Psychic 5 video board.
// Used by the timing generator, the screen-capture model and the sprite/tilemap fetchers.
package psychic5_video_pkg;

  localparam int unsigned CountW = 9;

  typedef logic [CountW-1:0] count_t;

  // Counter ranges: both counters run up to 511 and reload their first value.
  localparam count_t HFirst = 9'd128;
  localparam count_t HLast  = 9'd511;
  localparam count_t VFirst = 9'd248;
  localparam count_t VLast  = 9'd511;

  // 256x224 display window. A display line starts at HActBegin in V = n and ends at
  // HActEnd in V = n+1.
  localparam count_t HActBegin = 9'd269;
  localparam count_t HActEnd   = 9'd140;
  localparam count_t VActFirst = 9'd272;
  localparam count_t VActLast  = 9'd495;

  // Inclusive sync windows.
  localparam count_t HSyncBegin = 9'd176;
  localparam count_t HSyncEnd   = 9'd207;
  localparam count_t VSyncBegin = 9'd504;
  localparam count_t VSyncEnd   = 9'd507;

  typedef struct packed {
    logic de;
    logic hblank_n;
    logic vblank_n;
    logic hsync_n;
    logic vsync_n;
    logic line_start;
    logic frame_start;
  } flags_t;

  localparam flags_t FlagsReset = '{
    de:          1'b0,
    hblank_n:    1'b0,
    vblank_n:    1'b0,
    hsync_n:     1'b1,
    vsync_n:     1'b1,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  // True when h lies in a window that wraps past the end of the line (begin > end).
  function automatic logic in_hwrap_window(count_t h, count_t win_begin, count_t win_end);
    return (h >= win_begin) || (h <= win_end);
  endfunction

  // True when x lies in the inclusive, non-wrapping range [lo, hi].
  function automatic logic in_range(count_t x, count_t lo, count_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/psychic5_video_timing_if.sv
// Raster bus from the video timing generator to the pixel/palette pipeline.
interface psychic5_video_timing_if;
  import psychic5_video_pkg::*;

  count_t      o_HCOUNTER;
  count_t      o_VCOUNTER;
  logic        o_DE;
  logic        o_HBLANK_n;
  logic        o_VBLANK_n;
  logic        o_HSYNC_n;
  logic        o_VSYNC_n;
  logic        o_LINE_START;
  logic        o_FRAME_START;
  logic [15:0] o_FRAME;

  modport master (
    output o_HCOUNTER, o_VCOUNTER, o_DE, o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n,
           o_LINE_START, o_FRAME_START, o_FRAME
  );

  modport slave (
    input o_HCOUNTER, o_VCOUNTER, o_DE, o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n,
          o_LINE_START, o_FRAME_START, o_FRAME
  );

endinterface

// File: rtl/psychic5_wrap_counter.sv
// Up-counter that reloads First after reaching Last. Exposes its next-state value so
// downstream flags can be registered in step with the count.
module psychic5_wrap_counter
  import psychic5_video_pkg::*;
#(
  parameter count_t First = '0,
  parameter count_t Last  = '1
) (
  input  logic   i_EMU_MCLK,
  input  logic   i_EMU_MRST_n,
  input  logic   en,
  output count_t count,
  output count_t count_next,
  output logic   carry
);

  count_t cnt_q, cnt_d;

  // Next count: advance on enable, reload at Last.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == Last) ? First : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      cnt_q <= First;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count      = cnt_q;
  assign count_next = cnt_d;
  assign carry      = en && (cnt_q == Last);

endmodule

// File: rtl/psychic5_video_timing.sv
// Raster counters plus blanking, sync and start strobes for the Psychic 5 video board.
// All flags are registered from the next-state counts so they line up with the counts.
// Optional screen centering (sync window offsets) is built when
// PSYCHIC5_SCREEN_CENTERING_EN is defined.
module psychic5_video_timing
  import psychic5_video_pkg::*;
#(
  parameter count_t H_FIRST     = HFirst,
  parameter count_t V_FIRST     = VFirst,
  parameter count_t HACT_BEGIN  = HActBegin,
  parameter count_t HACT_END    = HActEnd,
  parameter count_t VACT_FIRST  = VActFirst,
  parameter count_t VACT_LAST   = VActLast,
  parameter count_t HSYNC_BEGIN = HSyncBegin,
  parameter count_t HSYNC_END   = HSyncEnd,
  parameter count_t VSYNC_BEGIN = VSyncBegin,
  parameter count_t VSYNC_END   = VSyncEnd
) (
  input  logic                     i_EMU_MCLK,
  input  logic                     i_EMU_MRST_n,
  input  logic                     i_EMU_CLK6MPCEN_n,
  psychic5_video_timing_if.master  vid
`ifdef PSYCHIC5_SCREEN_CENTERING_EN
  ,
  input  logic signed [3:0]        i_HOFFSET,
  input  logic signed [2:0]        i_VOFFSET
`endif
);

  // Parameter legality: sync must sit inside blanking.
  if (!((HACT_END < HSYNC_BEGIN) && (HSYNC_BEGIN <= HSYNC_END) &&
        (HSYNC_END < HACT_BEGIN))) begin : g_bad_hparams
    $error("psychic5_video_timing: horizontal sync window overlaps the active window");
  end
  if (!((VACT_LAST + 9'd1) < VSYNC_BEGIN)) begin : g_bad_vparams
    $error("psychic5_video_timing: vertical sync window overlaps the active window");
  end

  localparam count_t VActFirstNext = VACT_FIRST + 9'd1;
  localparam count_t VActLastNext  = VACT_LAST + 9'd1;

  logic        cen;
  count_t      h_count, h_next, v_count, v_next;
  logic        h_wrap, v_wrap;
  logic        hsync_hit, vsync_hit;
  flags_t      flags_q, flags_d;
  logic [15:0] frame_q;

  assign cen = ~i_EMU_CLK6MPCEN_n;

  psychic5_wrap_counter #(
    .First (H_FIRST),
    .Last  (HLast)
  ) u_hcount (
    .i_EMU_MCLK   (i_EMU_MCLK),
    .i_EMU_MRST_n (i_EMU_MRST_n),
    .en           (cen),
    .count        (h_count),
    .count_next   (h_next),
    .carry        (h_wrap)
  );

  // V steps only on the end-of-line wrap.
  psychic5_wrap_counter #(
    .First (V_FIRST),
    .Last  (VLast)
  ) u_vcount (
    .i_EMU_MCLK   (i_EMU_MCLK),
    .i_EMU_MRST_n (i_EMU_MRST_n),
    .en           (h_wrap),
    .count        (v_count),
    .count_next   (v_next),
    .carry        (v_wrap)
  );

`ifdef PSYCHIC5_SCREEN_CENTERING_EN
  logic [3:0]        hoff_q;
  logic [2:0]        voff_q;
  logic [CountW:0]   hs_lo, hs_hi, vs_lo, vs_hi;

  // Offsets latch once per frame, leaving the first line, so a frame never sees a change.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      hoff_q <= '0;
      voff_q <= '0;
    end else if (h_wrap && (v_count == V_FIRST)) begin
      hoff_q <= i_HOFFSET;
      voff_q <= i_VOFFSET;
    end
  end

  // Shifted sync windows, one bit wider so a signed offset cannot alias.
  always_comb begin
    hs_lo     = {1'b0, HSYNC_BEGIN} + {{(CountW - 3){hoff_q[3]}}, hoff_q};
    hs_hi     = {1'b0, HSYNC_END}   + {{(CountW - 3){hoff_q[3]}}, hoff_q};
    vs_lo     = {1'b0, VSYNC_BEGIN} + {{(CountW - 2){voff_q[2]}}, voff_q};
    vs_hi     = {1'b0, VSYNC_END}   + {{(CountW - 2){voff_q[2]}}, voff_q};
    hsync_hit = ({1'b0, h_next} >= hs_lo) && ({1'b0, h_next} <= hs_hi);
    vsync_hit = ({1'b0, v_next} >= vs_lo) && ({1'b0, v_next} <= vs_hi);
  end
`else
  assign hsync_hit = in_range(h_next, HSYNC_BEGIN, HSYNC_END);
  assign vsync_hit = in_range(v_next, VSYNC_BEGIN, VSYNC_END);
`endif

  // Flags for the position the counters move to on this edge.
  always_comb begin
    flags_d          = FlagsReset;
    flags_d.hblank_n = in_hwrap_window(h_next, HACT_BEGIN, HACT_END);
    // A display line begins in V = n and finishes in V = n+1 after the H wrap.
    flags_d.vblank_n = (in_range(v_next, VACT_FIRST, VACT_LAST) && (h_next >= HACT_BEGIN)) ||
                       (in_range(v_next, VActFirstNext, VActLastNext) && (h_next <= HACT_END));
    flags_d.de          = flags_d.hblank_n && flags_d.vblank_n;
    flags_d.hsync_n     = ~hsync_hit;
    flags_d.vsync_n     = ~vsync_hit;
    flags_d.line_start  = (h_next == HACT_BEGIN);
    flags_d.frame_start = (h_next == HACT_BEGIN) && (v_next == VACT_FIRST);
  end

  // Flags and pulses update only on enabled edges, so pulses hold while disabled.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      flags_q <= FlagsReset;
    end else if (cen) begin
      flags_q <= flags_d;
    end
  end

  // Frame counter advances on the same edge V wraps.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      frame_q <= '0;
    end else if (v_wrap) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  assign vid.o_HCOUNTER    = h_count;
  assign vid.o_VCOUNTER    = v_count;
  assign vid.o_DE          = flags_q.de;
  assign vid.o_HBLANK_n    = flags_q.hblank_n;
  assign vid.o_VBLANK_n    = flags_q.vblank_n;
  assign vid.o_HSYNC_n     = flags_q.hsync_n;
  assign vid.o_VSYNC_n     = flags_q.vsync_n;
  assign vid.o_LINE_START  = flags_q.line_start;
  assign vid.o_FRAME_START = flags_q.frame_start;
  assign vid.o_FRAME       = frame_q;

endmodule

// File: tb/tb_psychic5_video_timing.sv
// Directed bench for psychic5_video_timing. A second instance with its own reset is
// used for the asynchronous mid-frame reset check so the first can run on to the frame wrap.
module tb_psychic5_video_timing;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  logic cen_n;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned de_cnt = 0;
  int unsigned fs_cnt = 0;

  psychic5_video_timing_if vid1 ();
  psychic5_video_timing_if vid2 ();

  always #5 clk = ~clk;

  psychic5_video_timing u_dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_MRST_n      (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .vid               (vid1)
`ifdef PSYCHIC5_SCREEN_CENTERING_EN
    ,
    .i_HOFFSET         (4'sd0),
    .i_VOFFSET         (3'sd0)
`endif
  );

  psychic5_video_timing u_dut2 (
    .i_EMU_MCLK        (clk),
    .i_EMU_MRST_n      (rst2_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .vid               (vid2)
`ifdef PSYCHIC5_SCREEN_CENTERING_EN
    ,
    .i_HOFFSET         (4'sd0),
    .i_VOFFSET         (3'sd0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One MCLK edge, sampled 1 time unit later; tallies DE pixels and frame strobes.
  task automatic step();
    @(posedge clk);
    #1;
    if (cen_n == 1'b0) begin
      de_cnt += 32'(vid1.o_DE);
      fs_cnt += 32'(vid1.o_FRAME_START);
    end
  endtask

  task automatic run_to(input int unsigned v, input int unsigned h);
    int unsigned guard = 0;
    while (!((32'(vid1.o_VCOUNTER) == v) && (32'(vid1.o_HCOUNTER) == h)) && guard < 110000) begin
      step();
      guard++;
    end
    chk($sformatf("reach V%0d H%0d", v, h), 32'(guard < 110000), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    cen_n  = 1'b0;
    #23;
    chk("rst H", 32'(vid1.o_HCOUNTER), 128);
    chk("rst V", 32'(vid1.o_VCOUNTER), 248);
    chk("rst FRAME", 32'(vid1.o_FRAME), 0);
    chk("rst DE", 32'(vid1.o_DE), 0);
    chk("rst HBLANK_n", 32'(vid1.o_HBLANK_n), 0);
    chk("rst VBLANK_n", 32'(vid1.o_VBLANK_n), 0);
    chk("rst HSYNC_n", 32'(vid1.o_HSYNC_n), 1);
    chk("rst VSYNC_n", 32'(vid1.o_VSYNC_n), 1);
    chk("rst LINE_START", 32'(vid1.o_LINE_START), 0);
    chk("rst FRAME_START", 32'(vid1.o_FRAME_START), 0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // First enable after release.
    step();
    chk("first H", 32'(vid1.o_HCOUNTER), 129);
    chk("first V", 32'(vid1.o_VCOUNTER), 248);
    chk("first DE", 32'(vid1.o_DE), 0);
    chk("first HSYNC_n", 32'(vid1.o_HSYNC_n), 1);
    chk("first FRAME", 32'(vid1.o_FRAME), 0);
    chk("first HBLANK_n", 32'(vid1.o_HBLANK_n), 1);

    // Edge of the first display pixel.
    run_to(272, 268);
    chk("pre-first DE", 32'(vid1.o_DE), 0);
    chk("pre-first HBLANK_n", 32'(vid1.o_HBLANK_n), 0);
    step();
    chk("first-pixel DE", 32'(vid1.o_DE), 1);
    chk("first-pixel LINE_START", 32'(vid1.o_LINE_START), 1);
    chk("first-pixel FRAME_START", 32'(vid1.o_FRAME_START), 1);

    // Line wrap carries into V.
    run_to(300, 511);
    chk("V300 H511 DE", 32'(vid1.o_DE), 1);
    step();
    chk("wrap H", 32'(vid1.o_HCOUNTER), 128);
    chk("wrap V", 32'(vid1.o_VCOUNTER), 301);
    chk("wrap DE", 32'(vid1.o_DE), 1);
    step();
    chk("post-wrap H", 32'(vid1.o_HCOUNTER), 129);
    chk("post-wrap V", 32'(vid1.o_VCOUNTER), 301);

    // Freeze with LINE_START asserted.
    run_to(301, 269);
    chk("pre-freeze LINE_START", 32'(vid1.o_LINE_START), 1);
    cen_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("freeze H", 32'(vid1.o_HCOUNTER), 269);
    chk("freeze V", 32'(vid1.o_VCOUNTER), 301);
    chk("freeze LINE_START", 32'(vid1.o_LINE_START), 1);
    chk("freeze DE", 32'(vid1.o_DE), 1);
    chk("freeze HBLANK_n", 32'(vid1.o_HBLANK_n), 1);
    cen_n = 1'b0;
    step();
    chk("resume H", 32'(vid1.o_HCOUNTER), 270);
    chk("resume LINE_START", 32'(vid1.o_LINE_START), 0);

    // Asynchronous reset of the second instance between edges.
    run_to(400, 300);
    chk("dut2 tracking H", 32'(vid2.o_HCOUNTER), 300);
    rst2_n = 1'b0;
    #2;
    chk("async H", 32'(vid2.o_HCOUNTER), 128);
    chk("async V", 32'(vid2.o_VCOUNTER), 248);
    chk("async DE", 32'(vid2.o_DE), 0);
    chk("async HBLANK_n", 32'(vid2.o_HBLANK_n), 0);
    chk("async VBLANK_n", 32'(vid2.o_VBLANK_n), 0);
    chk("async HSYNC_n", 32'(vid2.o_HSYNC_n), 1);
    chk("async LINE_START", 32'(vid2.o_LINE_START), 0);
    chk("unaffected H", 32'(vid1.o_HCOUNTER), 300);

    // Last display pixel.
    run_to(496, 140);
    chk("last-pixel DE", 32'(vid1.o_DE), 1);
    step();
    chk("after-last DE", 32'(vid1.o_DE), 0);

    // Sync windows.
    run_to(504, 175);
    chk("H175 HSYNC_n", 32'(vid1.o_HSYNC_n), 1);
    chk("V504 VSYNC_n", 32'(vid1.o_VSYNC_n), 0);
    step();
    chk("H176 HSYNC_n", 32'(vid1.o_HSYNC_n), 0);
    run_to(504, 207);
    chk("H207 HSYNC_n", 32'(vid1.o_HSYNC_n), 0);
    step();
    chk("H208 HSYNC_n", 32'(vid1.o_HSYNC_n), 1);

    // Frame wrap.
    run_to(511, 511);
    chk("pre-wrap FRAME", 32'(vid1.o_FRAME), 0);
    chk("V511 VSYNC_n", 32'(vid1.o_VSYNC_n), 1);
    chk("DE per frame", de_cnt, 57344);
    chk("FRAME_START per frame", fs_cnt, 1);
    step();
    chk("frame-wrap H", 32'(vid1.o_HCOUNTER), 128);
    chk("frame-wrap V", 32'(vid1.o_VCOUNTER), 248);
    chk("frame-wrap FRAME", 32'(vid1.o_FRAME), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
